// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice.
//   arb_state_t      : arbiter FSM encoding (IDLE=0, ISSUE=1, WAIT_BUSY=2)
//   grant_idx_width  : width of a requester index (never below 1 bit)
//   hold_cnt_width   : width of the mid-frame hold counter for a timeout value
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_BUSY = 2'd2
    } arb_state_t;

    // A single requester still needs a 1-bit index so ports never collapse.
    function automatic int grant_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Counter must be able to hold the timeout value itself; a timeout of 0
    // (never release) still gets a 1-bit saturating counter.
    function automatic int hold_cnt_width(input int t);
        return (t <= 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester byte streams and the UART transmit handshake.
//   req_valid  [NUM_REQ]   : per-requester byte available
//   req_data   [8*NUM_REQ] : requester i owns bits [8i+7:8i]
//   req_last   [NUM_REQ]   : byte is the final byte of its frame
//   req_ready  [NUM_REQ]   : one-hot accept from the arbiter
//   uart_transmit          : one-cycle start pulse to the UART
//   uart_tx_byte [8]       : byte presented to the UART
//   uart_tx_free           : UART transmitter idle
// Modports:
//   master : requesters plus UART (drive valid/data/last and tx_free)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_transmit;
    logic [7:0]           uart_tx_byte;
    logic                 uart_tx_free;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output uart_tx_free,
        input  req_ready,
        input  uart_transmit,
        input  uart_tx_byte
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  uart_tx_free,
        output req_ready,
        output uart_transmit,
        output uart_tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches the request vector starting
// one position after ptr, wrapping around, and returns the first hit.
//   req [NUM_REQ] : request vector
//   ptr [IDX_W]   : index of the most recent owner (lowest priority)
//   any           : at least one request is set
//   idx [IDX_W]   : selected index (0 when any is low)
// ---------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = grant_idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    // cand[k] is the requester at search distance k+1 from ptr, so cand[0]
    // has the highest priority and cand[NUM_REQ-1] (== ptr) the lowest.
    logic [IDX_W-1:0]   cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((int'(ptr) + gi + 1) % NUM_REQ);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Walk from lowest to highest priority so the nearest hit wins.
    always_comb begin
        any = |hit;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// A requester is granted round-robin and keeps the UART for a whole frame
// (until its last byte), or until it leaves valid low mid-frame for
// HOLD_TIMEOUT cycles. Each byte is issued only when the UART reports idle,
// and the next byte waits until the UART has visibly gone busy.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : requester streams and UART handshake
//   grant_idx    : current or most recent owner
//   busy         : a frame is locked
//   timeout_evt  : one-cycle pulse when a lock is released by timeout
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int HOLD_TIMEOUT = 4096,
    localparam int IDX_W       = grant_idx_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_arbiter_if.slave     bus,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 busy,
    output logic                 timeout_evt
);

    localparam int               CNT_W      = hold_cnt_width(HOLD_TIMEOUT);
    localparam bit               TIMEOUT_EN = (HOLD_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT  =
        CNT_W'((HOLD_TIMEOUT > 0) ? (HOLD_TIMEOUT - 1) : 0);

    arb_state_t         state_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [CNT_W-1:0]   hold_cnt_reg;
    logic               last_reg;

    logic [7:0]         data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] ready_vec;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               grant_valid;
    logic               grant_last;
    logic [7:0]         grant_data;
    logic               xfer;

    // ---------------------------------------------------------------------
    // Requester selection
    // ---------------------------------------------------------------------
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    // ---------------------------------------------------------------------
    // Per-requester unpacking and one-hot ready
    // ---------------------------------------------------------------------
    // Ready is combinational so a byte can transfer in the very first ISSUE
    // cycle the UART is idle; only the granted requester ever sees it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi]  = bus.req_data[8*gi +: 8];
            assign ready_vec[gi] = (state_reg == ARB_ISSUE) &&
                                   bus.uart_tx_free &&
                                   bus.req_valid[gi] &&
                                   (grant_idx == IDX_W'(gi));
        end
    endgenerate

    assign bus.req_ready = ready_vec;
    assign grant_valid   = bus.req_valid[grant_idx];
    assign grant_last    = bus.req_last[grant_idx];
    assign grant_data    = data_arr[grant_idx];
    assign xfer          = (state_reg == ARB_ISSUE) && bus.uart_tx_free && grant_valid;

    // ---------------------------------------------------------------------
    // Arbiter FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ARB_IDLE;
            rr_ptr_reg        <= '0;
            hold_cnt_reg      <= '0;
            last_reg          <= 1'b0;
            grant_idx         <= '0;
            busy              <= 1'b0;
            timeout_evt       <= 1'b0;
            bus.uart_transmit <= 1'b0;
            bus.uart_tx_byte  <= '0;
        end else begin
            // Both pulses last exactly one cycle.
            bus.uart_transmit <= 1'b0;
            timeout_evt       <= 1'b0;

            case (state_reg)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_idx    <= pick_idx;
                        busy         <= 1'b1;
                        hold_cnt_reg <= '0;
                        state_reg    <= ARB_ISSUE;
                    end
                end

                ARB_ISSUE: begin
                    if (xfer) begin
                        bus.uart_transmit <= 1'b1;
                        bus.uart_tx_byte  <= grant_data;
                        last_reg          <= grant_last;
                        hold_cnt_reg      <= '0;
                        state_reg         <= ARB_WAIT_BUSY;
                    end else if (!grant_valid) begin
                        if (TIMEOUT_EN && (hold_cnt_reg == CNT_LIMIT)) begin
                            // Owner stalled too long: drop the lock and let
                            // everyone else ahead of it in the next round.
                            timeout_evt  <= 1'b1;
                            rr_ptr_reg   <= grant_idx;
                            busy         <= 1'b0;
                            hold_cnt_reg <= '0;
                            state_reg    <= ARB_IDLE;
                        end else if (hold_cnt_reg != CNT_MAX) begin
                            hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
                        end
                    end
                end

                ARB_WAIT_BUSY: begin
                    // tx_free falling proves the UART latched the byte; only
                    // then is it safe to look at tx_free again for the next.
                    if (!bus.uart_tx_free) begin
                        if (last_reg) begin
                            rr_ptr_reg <= grant_idx;
                            busy       <= 1'b0;
                            state_reg  <= ARB_IDLE;
                        end else begin
                            state_reg  <= ARB_ISSUE;
                        end
                    end
                end

                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with two requesters, a queue-driven
// requester model and a simple UART busy model that logs every issued byte.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ      = 2;
    localparam int HOLD_TIMEOUT = 16;
    localparam int IW           = grant_idx_width(NUM_REQ);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] grant_idx;
    logic          busy;
    logic          timeout_evt;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .HOLD_TIMEOUT (HOLD_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Requester model: each queue entry is {last, byte}
    // ------------------------------------------------------------------
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    int         gap0 = 0;
    int         gap1 = 0;
    int         max_gap = 0;

    initial begin
        logic acc0, acc1;
        logic [NUM_REQ-1:0] one;
        one = 1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            acc0 = bus.req_valid[0] & bus.req_ready[0];
            acc1 = bus.req_valid[1] & bus.req_ready[1];
            if (!rst && (bus.req_ready != '0)) begin
                check("ready_onehot", bus.req_ready, one << grant_idx);
                check("ready_needs_valid", bus.req_ready & ~bus.req_valid, 0);
            end
            @(posedge clk);
            #1;
            if (rst) begin
                gap0 = 0;
                gap1 = 0;
            end
            if (acc0 && q0.size() > 0) begin
                void'(q0.pop_front());
                gap0 = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            end
            if (acc1 && q1.size() > 0) begin
                void'(q1.pop_front());
                gap1 = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            end
            if (gap0 > 0) begin
                gap0--;
                bus.req_valid[0] = 1'b0;
            end else if (q0.size() > 0) begin
                bus.req_valid[0]  = 1'b1;
                bus.req_data[7:0] = q0[0][7:0];
                bus.req_last[0]   = q0[0][8];
            end else begin
                bus.req_valid[0] = 1'b0;
            end
            if (gap1 > 0) begin
                gap1--;
                bus.req_valid[1] = 1'b0;
            end else if (q1.size() > 0) begin
                bus.req_valid[1]   = 1'b1;
                bus.req_data[15:8] = q1[0][7:0];
                bus.req_last[1]    = q1[0][8];
            end else begin
                bus.req_valid[1] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // UART model: takes a byte on transmit, stays busy uart_busy cycles
    // (0 selects a random 1..6 per byte). Logs {owner, byte, cycle}.
    // ------------------------------------------------------------------
    int   uart_busy = 40;
    int   ucnt = 0;
    int   log_g [$];
    int   log_b [$];
    int   log_t [$];

    initial begin
        logic       tr, fr, prev_tr;
        logic [7:0] by;
        int         g;
        prev_tr = 1'b0;
        bus.uart_tx_free = 1'b1;
        forever begin
            @(negedge clk);
            tr = bus.uart_transmit;
            fr = bus.uart_tx_free;
            by = bus.uart_tx_byte;
            g  = int'(grant_idx);
            @(posedge clk);
            #1;
            if (rst) begin
                bus.uart_tx_free = 1'b1;
                ucnt    = 0;
                prev_tr = 1'b0;
            end else begin
                if (tr) begin
                    check("tx_only_when_free", fr, 1);
                    check("tx_not_back_to_back", prev_tr, 0);
                    log_g.push_back(g);
                    log_b.push_back(int'(by));
                    log_t.push_back(cyc);
                    $display("tx: req=%0d byte=0x%02h cyc=%0d", g, by, cyc);
                    bus.uart_tx_free = 1'b0;
                    ucnt = (uart_busy > 0) ? uart_busy : $urandom_range(1, 6);
                end else if (!bus.uart_tx_free) begin
                    if (ucnt <= 1) bus.uart_tx_free = 1'b1;
                    else ucnt--;
                end
                prev_tr = tr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status monitor
    // ------------------------------------------------------------------
    int   t_busy_fall = 0;
    int   t_timeout   = 0;
    int   to_count    = 0;

    initial begin
        logic busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_prev && !busy) t_busy_fall = cyc;
            busy_prev = busy;
            if (timeout_evt) begin
                to_count++;
                t_timeout = cyc;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic release_reset();
        repeat (3) @(negedge clk);
        q0.delete();
        q1.delete();
        log_g.delete();
        log_b.delete();
        log_t.delete();
        to_count = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        release_reset();
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        int i = 0;
        while (log_b.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, (log_b.size() >= n), 1);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_transmit"}, bus.uart_transmit, 0);
        check({pfx, "_tx_byte"}, bus.uart_tx_byte, 0);
        check({pfx, "_ready"}, bus.req_ready, 0);
        check({pfx, "_grant_idx"}, grant_idx, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_timeout_evt"}, timeout_evt, 0);
    endtask

    // ------------------------------------------------------------------
    // Directed expectations
    // ------------------------------------------------------------------
    int cont_g [6] = '{1, 1, 1, 0, 0, 0};
    int cont_b [6] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};

    logic [8:0] e0 [$];
    logic [8:0] e1 [$];

    initial begin
        int total;
        logic [8:0] it;

        // ---------------- reset state ----------------
        max_gap   = 0;
        uart_busy = 40;
        release_reset();
        check_outputs_zero("reset");

        // ---------------- single frame ----------------
        q0.push_back({1'b0, 8'h55});
        q0.push_back({1'b1, 8'hA3});
        wait_log("single_wait", 2, 400);
        repeat (4) @(negedge clk);
        check("single_count", log_b.size(), 2);
        if (log_b.size() >= 2) begin
            check("single_b0", log_b[0], 8'h55);
            check("single_b1", log_b[1], 8'hA3);
            check("single_g0", log_g[0], 0);
            check("single_g1", log_g[1], 0);
            check("single_busy_fall", t_busy_fall - log_t[1], 1);
        end
        check("single_busy_low", busy, 0);
        check("single_grant_idx", grant_idx, 0);

        // ---------------- contention ----------------
        uart_busy = 12;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            q0.push_back({(k == 2), 8'(8'h20 + k)});
            q1.push_back({(k == 2), 8'(8'h10 + k)});
        end
        wait_log("cont_wait", 6, 600);
        for (int i = 0; i < 6 && i < log_b.size(); i++) begin
            check($sformatf("cont_g%0d", i), log_g[i], cont_g[i]);
            check($sformatf("cont_b%0d", i), log_b[i], cont_b[i]);
        end

        // ---------------- fairness ----------------
        do_reset();
        for (int k = 0; k < 4; k++) begin
            q0.push_back({1'b1, 8'(8'h30 + k)});
            q1.push_back({1'b1, 8'(8'h40 + k)});
        end
        wait_log("fair_wait", 8, 800);
        for (int i = 0; i < 8 && i < log_b.size(); i++) begin
            check($sformatf("fair_g%0d", i), log_g[i], (i % 2 == 0) ? 1 : 0);
            check($sformatf("fair_b%0d", i), log_b[i],
                  (i % 2 == 0) ? (8'h40 + i / 2) : (8'h30 + i / 2));
        end

        // ---------------- random back-pressure ----------------
        uart_busy = 0;
        max_gap   = 3;
        do_reset();
        total = 0;
        while (total < 256) begin
            int r, len;
            r   = $urandom_range(0, 1);
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                it = {(k == len - 1), 8'($urandom)};
                if (r == 0) begin
                    q0.push_back(it);
                    e0.push_back(it);
                end else begin
                    q1.push_back(it);
                    e1.push_back(it);
                end
            end
            total += len;
        end
        wait_log("rand_wait", total, 20000);
        begin
            logic mid;
            int   prev_g;
            mid    = 1'b0;
            prev_g = 0;
            for (int i = 0; i < log_b.size(); i++) begin
                if (mid) check("rand_atomic", log_g[i], prev_g);
                if (log_g[i] == 0 && e0.size() > 0) it = e0.pop_front();
                else if (log_g[i] == 1 && e1.size() > 0) it = e1.pop_front();
                else it = 9'h1ff;
                check("rand_byte", log_b[i], int'(it[7:0]));
                mid    = ~it[8];
                prev_g = log_g[i];
            end
        end
        check("rand_left0", e0.size(), 0);
        check("rand_left1", e1.size(), 0);
        check("rand_no_timeout", to_count, 0);

        // ---------------- timeout release ----------------
        uart_busy = 12;
        max_gap   = 0;
        do_reset();
        q0.push_back({1'b0, 8'h61});
        wait_log("to_first", 1, 200);
        q1.push_back({1'b1, 8'h62});
        wait_log("to_second", 2, 400);
        check("to_count", to_count, 1);
        if (log_b.size() >= 2) begin
            check("to_first_g", log_g[0], 0);
            check("to_delay", t_timeout - log_t[0], 17);
            check("to_next_g", log_g[1], 1);
            check("to_next_b", log_b[1], 8'h62);
            check("to_order", (log_t[1] > t_timeout), 1);
        end

        // ---------------- reset mid-frame ----------------
        do_reset();
        q0.push_back({1'b0, 8'hB0});
        q0.push_back({1'b0, 8'hB1});
        q0.push_back({1'b0, 8'hB2});
        q0.push_back({1'b1, 8'hB3});
        wait_log("rst_wait", 2, 400);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        q0.delete();
        release_reset();
        q1.push_back({1'b1, 8'h7E});
        wait_log("rst_after_wait", 1, 200);
        repeat (30) @(negedge clk);
        check("rst_after_count", log_b.size(), 1);
        if (log_b.size() >= 1) begin
            check("rst_after_b", log_b[0], 8'h7E);
            check("rst_after_g", log_g[0], 1);
        end
        check("rst_after_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
